// File: rtl/node_scheduler_if.sv
// node_scheduler_if
// Connects the scheduler to the weight memory and to the shared node instance.
//   w_rd / w_addr  : weight-memory read strobe and row address (scheduler -> memory)
//   w_data         : row read data, weights low, bias in top WEIGHT_BITS; valid 1 cycle after w_rd
//   node_inputs    : layer input vector presented to the node
//   node_weights   : weights of the current neuron
//   node_bias      : bias of the current neuron
//   node_outputs   : node result for the current neuron (node -> scheduler)
// master modport = scheduler side, slave modport = memory/node side.
interface node_scheduler_if #(
    parameter int N_INPUTS    = 16,
    parameter int INPUT_BITS  = 3,
    parameter int WEIGHT_BITS = 3,
    parameter int OUTPUT_BITS = 3,
    parameter int N_NEURONS   = 8
) ();
    localparam int ADDR_W = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;

    logic                                 w_rd;
    logic [ADDR_W-1:0]                    w_addr;
    logic [(N_INPUTS+1)*WEIGHT_BITS-1:0]  w_data;
    logic [N_INPUTS*INPUT_BITS-1:0]       node_inputs;
    logic [N_INPUTS*WEIGHT_BITS-1:0]      node_weights;
    logic [WEIGHT_BITS-1:0]               node_bias;
    logic [OUTPUT_BITS-1:0]               node_outputs;

    modport master (
        output w_rd, w_addr, node_inputs, node_weights, node_bias,
        input  w_data, node_outputs
    );

    modport slave (
        input  w_rd, w_addr, node_inputs, node_weights, node_bias,
        output w_data, node_outputs
    );
endinterface

// File: rtl/node_scheduler.sv
// node_scheduler
// Time-multiplexes N_NEURONS neurons of one layer onto a single node instance.
// For each neuron: fetch its weight row, let the node settle for NODE_LATENCY
// cycles, then store the node result into that neuron's slice of out_vec.
//
// Ports:
//   clk, reset (async, active low)
//   start       : request a layer evaluation (accepted only in IDLE, abort wins)
//   abort       : cancel a running evaluation; already stored slices are kept
//   in_vec      : layer input vector, captured on start acceptance
//   busy        : high in FETCH/WAIT/EVAL/STORE
//   done        : one-cycle pulse after the last neuron is stored
//   out_vec     : layer result, neuron k at [k*OUTPUT_BITS +: OUTPUT_BITS]
//   cycle_count : busy cycles of the current run (only with NODE_SCHED_PERF_EN)
//   bus         : weight memory and node connections (node_scheduler_if.master)
//
// Optional feature macro: NODE_SCHED_PERF_EN adds the saturating cycle_count output.
module node_scheduler #(
    parameter int N_INPUTS     = 16,
    parameter int INPUT_BITS   = 3,
    parameter int WEIGHT_BITS  = 3,
    parameter int OUTPUT_BITS  = 3,
    parameter int N_NEURONS    = 8,
    parameter int NODE_LATENCY = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic                             abort,
    input  logic [N_INPUTS*INPUT_BITS-1:0]   in_vec,
    output logic                             busy,
    output logic                             done,
    output logic [N_NEURONS*OUTPUT_BITS-1:0] out_vec,
`ifdef NODE_SCHED_PERF_EN
    output logic [15:0]                      cycle_count,
`endif
    node_scheduler_if.master                 bus
);
    localparam int IDX_W = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
    localparam int LAT_W = (NODE_LATENCY > 1) ? $clog2(NODE_LATENCY) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_WAIT, S_EVAL, S_STORE, S_DONE
    } state_t;

    state_t                                state_q, state_d;
    logic [IDX_W-1:0]                      index_q, index_d;
    logic [LAT_W-1:0]                      lat_q, lat_d;
    logic [N_INPUTS*INPUT_BITS-1:0]        inputs_q, inputs_d;
    logic [N_INPUTS*WEIGHT_BITS-1:0]       weights_q, weights_d;
    logic [WEIGHT_BITS-1:0]                bias_q, bias_d;
    logic [N_NEURONS-1:0][OUTPUT_BITS-1:0] out_q, out_d;
    logic                                  w_rd_c;

    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        lat_d     = lat_q;
        inputs_d  = inputs_q;
        weights_d = weights_q;
        bias_d    = bias_q;
        out_d     = out_q;
        busy      = 1'b0;
        done      = 1'b0;
        w_rd_c    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d  = S_FETCH;
                    index_d  = '0;
                    inputs_d = in_vec;
                end
            end
            S_FETCH: begin
                busy    = 1'b1;
                w_rd_c  = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                busy      = 1'b1;
                weights_d = bus.w_data[N_INPUTS*WEIGHT_BITS-1:0];
                bias_d    = bus.w_data[(N_INPUTS+1)*WEIGHT_BITS-1 -: WEIGHT_BITS];
                lat_d     = '0;
                state_d   = S_EVAL;
            end
            S_EVAL: begin
                busy = 1'b1;
                if (lat_q == LAT_W'(NODE_LATENCY - 1)) begin
                    state_d = S_STORE;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            S_STORE: begin
                busy           = 1'b1;
                out_d[index_q] = bus.node_outputs;
                if (index_q == IDX_W'(N_NEURONS - 1)) begin
                    state_d = S_DONE;
                end else begin
                    index_d = index_q + IDX_W'(1);
                    state_d = S_FETCH;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Abort wins over every busy-state transition; a STORE that coincides
        // with abort is dropped so the slice keeps its previous value.
        if (abort && busy) begin
            state_d = S_IDLE;
            out_d   = out_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            index_q   <= '0;
            lat_q     <= '0;
            inputs_q  <= '0;
            weights_q <= '0;
            bias_q    <= '0;
            out_q     <= '0;
        end else begin
            state_q   <= state_d;
            index_q   <= index_d;
            lat_q     <= lat_d;
            inputs_q  <= inputs_d;
            weights_q <= weights_d;
            bias_q    <= bias_d;
            out_q     <= out_d;
        end
    end

`ifdef NODE_SCHED_PERF_EN
    logic [15:0] cycle_count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_count_q <= '0;
        end else if (state_q == S_IDLE && state_d == S_FETCH) begin
            cycle_count_q <= '0;
        end else if (busy && cycle_count_q != 16'hFFFF) begin
            cycle_count_q <= cycle_count_q + 16'd1;
        end
    end

    assign cycle_count = cycle_count_q;
`endif

    // index_q is reset to 0 asynchronously, so the address is safe to drive
    // continuously; the memory only acts on it when w_rd is high.
    assign bus.w_rd         = w_rd_c;
    assign bus.w_addr       = index_q;
    assign bus.node_inputs  = inputs_q;
    assign bus.node_weights = weights_q;
    assign bus.node_bias    = bias_q;
    assign out_vec          = out_q;
endmodule

// File: tb/tb_node_scheduler.sv
module tb_node_scheduler;
    localparam int N_IN = 16;
    localparam int IB   = 3;
    localparam int WB   = 3;
    localparam int OB   = 3;
    localparam int NN   = 8;
    localparam int IW   = N_IN * IB;
    localparam int WW   = N_IN * WB;
    localparam int RW   = (N_IN + 1) * WB;
    localparam int OW   = NN * OB;

    logic          clk = 1'b0;
    logic          reset;
    logic          start1, abort1, start2, abort2;
    logic [IW-1:0] in_vec1, in_vec2;
    logic          busy1, done1, busy2, done2;
    logic [OW-1:0] out_vec1, out_vec2;
`ifdef NODE_SCHED_PERF_EN
    logic [15:0]   cc1, cc2;
`endif

    int pass_cnt = 0;
    int tot_cnt  = 0;
    int node_mode = 0;

    logic [WB-1:0] mem_w [NN][N_IN];
    logic [WB-1:0] mem_b [NN];

    always #5 clk = ~clk;

    node_scheduler_if #(.N_INPUTS(N_IN), .INPUT_BITS(IB), .WEIGHT_BITS(WB),
                        .OUTPUT_BITS(OB), .N_NEURONS(NN)) bus1 ();
    node_scheduler_if #(.N_INPUTS(N_IN), .INPUT_BITS(IB), .WEIGHT_BITS(WB),
                        .OUTPUT_BITS(OB), .N_NEURONS(NN)) bus2 ();

    node_scheduler #(.N_INPUTS(N_IN), .INPUT_BITS(IB), .WEIGHT_BITS(WB),
                     .OUTPUT_BITS(OB), .N_NEURONS(NN), .NODE_LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .abort(abort1), .in_vec(in_vec1),
        .busy(busy1), .done(done1), .out_vec(out_vec1),
`ifdef NODE_SCHED_PERF_EN
        .cycle_count(cc1),
`endif
        .bus(bus1)
    );

    node_scheduler #(.N_INPUTS(N_IN), .INPUT_BITS(IB), .WEIGHT_BITS(WB),
                     .OUTPUT_BITS(OB), .N_NEURONS(NN), .NODE_LATENCY(4)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .abort(abort2), .in_vec(in_vec2),
        .busy(busy2), .done(done2), .out_vec(out_vec2),
`ifdef NODE_SCHED_PERF_EN
        .cycle_count(cc2),
`endif
        .bus(bus2)
    );

    // ---------------- environment models ----------------
    function automatic logic [RW-1:0] row(input int k);
        logic [RW-1:0] r;
        for (int i = 0; i < N_IN; i++) r[i*WB +: WB] = mem_w[k][i];
        r[N_IN*WB +: WB] = mem_b[k];
        return r;
    endfunction

    // Node behaviour: mode 0 -> bias, mode 1 -> bias + dot(inputs, weights), truncated.
    function automatic logic [OB-1:0] node_fn(input logic [IW-1:0] ins, input logic [WW-1:0] ws,
                                              input logic [WB-1:0] b, input int mode);
        int s;
        s = int'(b);
        if (mode != 0)
            for (int i = 0; i < N_IN; i++) s += int'(ins[i*IB +: IB]) * int'(ws[i*WB +: WB]);
        return s[OB-1:0];
    endfunction

    // Expected layer result: every neuron's row applied to the captured input vector.
    function automatic logic [OW-1:0] ref_out(input logic [IW-1:0] iv, input int mode);
        logic [OW-1:0] o;
        logic [RW-1:0] r;
        for (int k = 0; k < NN; k++) begin
            r = row(k);
            o[k*OB +: OB] = node_fn(iv, r[WW-1:0], mem_b[k], mode);
        end
        return o;
    endfunction

    function automatic logic [IW-1:0] rand_vec();
        logic [IW-1:0] v;
        for (int i = 0; i < N_IN; i++) v[i*IB +: IB] = IB'($urandom);
        return v;
    endfunction

    task automatic rand_mem();
        for (int k = 0; k < NN; k++) begin
            for (int i = 0; i < N_IN; i++) mem_w[k][i] = WB'($urandom);
            mem_b[k] = WB'($urandom);
        end
    endtask

    always @(posedge clk) if (bus1.w_rd) bus1.w_data <= row(int'(bus1.w_addr));
    always @(posedge clk) if (bus2.w_rd) bus2.w_data <= row(int'(bus2.w_addr));
    assign bus1.node_outputs = node_fn(bus1.node_inputs, bus1.node_weights, bus1.node_bias, node_mode);
    assign bus2.node_outputs = node_fn(bus2.node_inputs, bus2.node_weights, bus2.node_bias, node_mode);

    // Start one run on dut1 and observe 40 cycles; cycle 1 is the first cycle
    // after the accepting edge. in_vec1 is scrambled after acceptance.
    task automatic run1(output int done_cyc, output int n_done, output int n_rd,
                        output int addr_err, output int n_busy);
        int exp_a;
        done_cyc = -1; n_done = 0; n_rd = 0; addr_err = 0; n_busy = 0; exp_a = 0;
        @(negedge clk); start1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b0; in_vec1 = rand_vec();
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (bus1.w_rd) begin
                if (int'(bus1.w_addr) != exp_a) addr_err++;
                exp_a++; n_rd++;
            end
            if (busy1) n_busy++;
            if (done1) begin n_done++; done_cyc = c; end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #12;
        tot_cnt++; if (busy1 !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy1); else pass_cnt++;
        tot_cnt++; if (done1 !== 1'b0) $display("FAIL reset_done: got %b want 0", done1); else pass_cnt++;
        tot_cnt++; if (bus1.w_rd !== 1'b0) $display("FAIL reset_w_rd: got %b want 0", bus1.w_rd); else pass_cnt++;
        tot_cnt++; if (bus1.w_addr !== '0) $display("FAIL reset_w_addr: got %0h want 0", bus1.w_addr); else pass_cnt++;
        tot_cnt++; if (bus1.node_inputs !== '0) $display("FAIL reset_node_inputs: got %0h want 0", bus1.node_inputs); else pass_cnt++;
        tot_cnt++; if (bus1.node_weights !== '0) $display("FAIL reset_node_weights: got %0h want 0", bus1.node_weights); else pass_cnt++;
        tot_cnt++; if (bus1.node_bias !== '0) $display("FAIL reset_node_bias: got %0h want 0", bus1.node_bias); else pass_cnt++;
        tot_cnt++; if (out_vec1 !== '0) $display("FAIL reset_out_vec: got %0h want 0", out_vec1); else pass_cnt++;
`ifdef NODE_SCHED_PERF_EN
        tot_cnt++; if (cc1 !== 16'd0) $display("FAIL reset_cycle_count: got %0d want 0", cc1); else pass_cnt++;
`endif
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        int dc, nd, nr, ae, nb;
        logic [IW-1:0] iv;
        for (int k = 0; k < NN; k++) begin
            for (int i = 0; i < N_IN; i++) mem_w[k][i] = WB'(k);
            mem_b[k] = WB'(k);
        end
        node_mode = 0;
        iv = rand_vec(); in_vec1 = iv;
        run1(dc, nd, nr, ae, nb);
        tot_cnt++; if (dc != 33) $display("FAIL directed_done_cycle: got %0d want 33", dc); else pass_cnt++;
        tot_cnt++; if (nd != 1) $display("FAIL directed_done_count: got %0d want 1", nd); else pass_cnt++;
        tot_cnt++; if (nr != 8 || ae != 0) $display("FAIL directed_w_addr_seq: got reads=%0d addr_errs=%0d want 8/0", nr, ae); else pass_cnt++;
        tot_cnt++; if (nb != 32) $display("FAIL directed_busy_cycles: got %0d want 32", nb); else pass_cnt++;
        tot_cnt++; if (bus1.node_inputs !== iv) $display("FAIL directed_input_latch: got %0h want %0h", bus1.node_inputs, iv); else pass_cnt++;
        for (int k = 0; k < NN; k++) begin
            tot_cnt++;
            if (out_vec1[k*OB +: OB] !== OB'(k)) $display("FAIL directed_slice%0d: got %0d want %0d", k, out_vec1[k*OB +: OB], k);
            else pass_cnt++;
        end
`ifdef NODE_SCHED_PERF_EN
        tot_cnt++; if (cc1 !== 16'd32) $display("FAIL directed_cycle_count: got %0d want 32", cc1); else pass_cnt++;
`endif
    endtask

    task automatic test_random();
        int dc, nd, nr, ae, nb;
        logic [IW-1:0] iv;
        for (int n = 0; n < 4; n++) begin
            rand_mem(); node_mode = 1;
            iv = rand_vec(); in_vec1 = iv;
            run1(dc, nd, nr, ae, nb);
            tot_cnt++; if (dc != 33 || nd != 1) $display("FAIL random%0d_done: got cycle=%0d count=%0d want 33/1", n, dc, nd); else pass_cnt++;
            tot_cnt++; if (out_vec1 !== ref_out(iv, 1)) $display("FAIL random%0d_out_vec: got %0h want %0h", n, out_vec1, ref_out(iv, 1)); else pass_cnt++;
        end
    endtask

    task automatic test_start_held();
        bit prev_done, prev_busy;
        int run_len, n_done, bad_restart, bad_run, addr_err, exp_a;
        logic [IW-1:0] iv;
        prev_done = 0; prev_busy = 0; run_len = 0; n_done = 0;
        bad_restart = 0; bad_run = 0; addr_err = 0; exp_a = 0;
        rand_mem(); node_mode = 1;
        iv = rand_vec(); in_vec1 = iv;
        @(negedge clk); start1 = 1'b1;
        for (int c = 1; c <= 102; c++) begin
            @(negedge clk);
            if (prev_done && busy1) bad_restart++;
            if (busy1) begin
                if (!prev_busy) begin run_len = 0; exp_a = 0; end
                run_len++;
            end else if (prev_busy && run_len != 32) bad_run++;
            if (bus1.w_rd) begin
                if (int'(bus1.w_addr) != exp_a) addr_err++;
                exp_a++;
            end
            if (done1) n_done++;
            prev_done = done1; prev_busy = busy1;
        end
        start1 = 1'b0;
        @(negedge clk);
        tot_cnt++; if (n_done != 3) $display("FAIL held_done_count: got %0d want 3", n_done); else pass_cnt++;
        tot_cnt++; if (bad_restart != 0) $display("FAIL held_restart_in_done: got %0d want 0", bad_restart); else pass_cnt++;
        tot_cnt++; if (bad_run != 0 || addr_err != 0) $display("FAIL held_run_shape: got bad_runs=%0d addr_errs=%0d want 0/0", bad_run, addr_err); else pass_cnt++;
        tot_cnt++; if (busy1 !== 1'b0) $display("FAIL held_idle_after: got %b want 0", busy1); else pass_cnt++;
        tot_cnt++; if (out_vec1 !== ref_out(iv, 1)) $display("FAIL held_out_vec: got %0h want %0h", out_vec1, ref_out(iv, 1)); else pass_cnt++;
    endtask

    task automatic test_abort();
        int dc, nd, nr, ae, nb, bad;
        logic [IW-1:0] iv;
        logic [OW-1:0] ref_a, ref_b;
        rand_mem(); node_mode = 1;
        iv = rand_vec(); in_vec1 = iv;
        run1(dc, nd, nr, ae, nb);
        ref_a = ref_out(iv, 1);
        tot_cnt++; if (out_vec1 !== ref_a) $display("FAIL abort_prior_run: got %0h want %0h", out_vec1, ref_a); else pass_cnt++;
        rand_mem();
        iv = rand_vec(); in_vec1 = iv;
        ref_b = ref_out(iv, 1);
        @(negedge clk); start1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b0;
        // neuron 3: FETCH cycle 13, WAIT 14, EVAL 15
        for (int c = 1; c <= 15; c++) @(negedge clk);
        tot_cnt++; if (busy1 !== 1'b1) $display("FAIL abort_busy_in_eval: got %b want 1", busy1); else pass_cnt++;
        abort1 = 1'b1;
        @(negedge clk); abort1 = 1'b0;
        tot_cnt++; if (busy1 !== 1'b0 || done1 !== 1'b0) $display("FAIL abort_to_idle: got busy=%b done=%b want 0/0", busy1, done1); else pass_cnt++;
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (busy1 !== 1'b0 || done1 !== 1'b0) bad++;
        end
        tot_cnt++; if (bad != 0) $display("FAIL abort_no_done: got %0d active cycles want 0", bad); else pass_cnt++;
        for (int k = 0; k < NN; k++) begin
            tot_cnt++;
            if (k < 3 && out_vec1[k*OB +: OB] !== ref_b[k*OB +: OB])
                $display("FAIL abort_slice%0d: got %0d want %0d", k, out_vec1[k*OB +: OB], ref_b[k*OB +: OB]);
            else if (k >= 3 && out_vec1[k*OB +: OB] !== ref_a[k*OB +: OB])
                $display("FAIL abort_slice%0d: got %0d want %0d", k, out_vec1[k*OB +: OB], ref_a[k*OB +: OB]);
            else pass_cnt++;
        end
        // abort has priority over start in IDLE
        @(negedge clk); start1 = 1'b1; abort1 = 1'b1;
        @(negedge clk); start1 = 1'b0; abort1 = 1'b0;
        tot_cnt++; if (busy1 !== 1'b0) $display("FAIL abort_start_priority: got busy=%b want 0", busy1); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int dc, nd, nr, ae, nb;
        logic [IW-1:0] iv;
        rand_mem(); node_mode = 1;
        in_vec1 = rand_vec();
        @(negedge clk); start1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b0;
        // neuron 5: FETCH cycle 21, WAIT 22
        for (int c = 1; c <= 22; c++) @(negedge clk);
        tot_cnt++; if (busy1 !== 1'b1) $display("FAIL rstmid_busy_before: got %b want 1", busy1); else pass_cnt++;
        reset = 1'b0;
        #1;
        tot_cnt++; if (busy1 !== 1'b0 || done1 !== 1'b0 || bus1.w_rd !== 1'b0)
            $display("FAIL rstmid_ctrl: got busy=%b done=%b w_rd=%b want 0", busy1, done1, bus1.w_rd); else pass_cnt++;
        tot_cnt++; if (bus1.w_addr !== '0 || bus1.node_inputs !== '0 || bus1.node_weights !== '0 || bus1.node_bias !== '0)
            $display("FAIL rstmid_node: got addr=%0h in=%0h w=%0h b=%0h want 0", bus1.w_addr, bus1.node_inputs, bus1.node_weights, bus1.node_bias); else pass_cnt++;
        tot_cnt++; if (out_vec1 !== '0) $display("FAIL rstmid_out_vec: got %0h want 0", out_vec1); else pass_cnt++;
`ifdef NODE_SCHED_PERF_EN
        tot_cnt++; if (cc1 !== 16'd0) $display("FAIL rstmid_cycle_count: got %0d want 0", cc1); else pass_cnt++;
`endif
        @(negedge clk); reset = 1'b1;
        iv = rand_vec(); in_vec1 = iv;
        run1(dc, nd, nr, ae, nb);
        tot_cnt++; if (dc != 33 || nd != 1) $display("FAIL rstmid_rerun_done: got cycle=%0d count=%0d want 33/1", dc, nd); else pass_cnt++;
        tot_cnt++; if (nr != 8 || ae != 0) $display("FAIL rstmid_rerun_addr: got reads=%0d addr_errs=%0d want 8/0", nr, ae); else pass_cnt++;
        tot_cnt++; if (out_vec1 !== ref_out(iv, 1)) $display("FAIL rstmid_rerun_out: got %0h want %0h", out_vec1, ref_out(iv, 1)); else pass_cnt++;
    endtask

    task automatic test_latency4();
        int dc, nd, nr, rd_err;
        logic [IW-1:0] iv;
        dc = -1; nd = 0; nr = 0; rd_err = 0;
        rand_mem(); node_mode = 1;
        iv = rand_vec(); in_vec2 = iv;
        @(negedge clk); start2 = 1'b1;
        @(posedge clk); #1 start2 = 1'b0; in_vec2 = rand_vec();
        for (int c = 1; c <= 70; c++) begin
            @(negedge clk);
            if (bus2.w_rd) begin
                nr++;
                if ((c - 1) % 7 != 0 || int'(bus2.w_addr) != (c - 1) / 7) rd_err++;
            end
            if (done2) begin nd++; dc = c; end
        end
        tot_cnt++; if (dc != 57 || nd != 1) $display("FAIL lat4_done: got cycle=%0d count=%0d want 57/1", dc, nd); else pass_cnt++;
        tot_cnt++; if (nr != 8 || rd_err != 0) $display("FAIL lat4_fetch_spacing: got reads=%0d errs=%0d want 8/0", nr, rd_err); else pass_cnt++;
        tot_cnt++; if (out_vec2 !== ref_out(iv, 1)) $display("FAIL lat4_out_vec: got %0h want %0h", out_vec2, ref_out(iv, 1)); else pass_cnt++;
`ifdef NODE_SCHED_PERF_EN
        tot_cnt++; if (cc2 !== 16'd56) $display("FAIL lat4_cycle_count: got %0d want 56", cc2); else pass_cnt++;
`endif
    endtask

    initial begin
        reset = 1'b0;
        start1 = 1'b0; abort1 = 1'b0; start2 = 1'b0; abort2 = 1'b0;
        in_vec1 = '0; in_vec2 = '0;
        test_reset();
        test_directed();
        test_random();
        test_start_held();
        test_abort();
        test_reset_mid();
        test_latency4();
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule

// File: doc/node_scheduler.md
NODE_SCHEDULER -- requirements
Module: node_scheduler

Interface
REQ-001 The block SHALL have a parameter N_INPUTS, default 16, giving the number of inputs per neuron.
REQ-002 The block SHALL have a parameter INPUT_BITS, default 3, giving the width of each input.
REQ-003 The block SHALL have a parameter WEIGHT_BITS, default 3, giving the width of each weight and of the bias.
REQ-004 The block SHALL have a parameter OUTPUT_BITS, default 3, giving the width of each neuron output.
REQ-005 The block SHALL have a parameter N_NEURONS, default 8, giving the number of neurons time-multiplexed onto one node instance.
REQ-006 The block SHALL have a parameter NODE_LATENCY, default 1, minimum 1, giving the cycles allowed for node settle.
REQ-007 clk  in  1  single clock; all state on rising edge.
REQ-008 reset  in  1  asynchronous, active-low reset.
REQ-009 start  in  1  request a layer evaluation.
REQ-010 abort  in  1  synchronous cancel of a running evaluation.
REQ-011 in_vec  in  N_INPUTS*INPUT_BITS  layer input vector, sampled on start acceptance.
REQ-012 busy  out  1  evaluation in progress.
REQ-013 done  out  1  one-cycle pulse when out_vec is complete.
REQ-014 w_rd  out  1  weight-memory read strobe.
REQ-015 w_addr  out  clog2(N_NEURONS), minimum 1  weight-memory row address, equal to the neuron index.
REQ-016 w_data  in  (N_INPUTS+1)*WEIGHT_BITS  row read data: weights in the low bits, bias in the top WEIGHT_BITS; valid exactly 1 cycle after w_rd.
REQ-017 node_inputs  out  N_INPUTS*INPUT_BITS  to node inputs_t.
REQ-018 node_weights  out  N_INPUTS*WEIGHT_BITS  to node weights_t.
REQ-019 node_bias  out  WEIGHT_BITS  to node bias_t.
REQ-020 node_outputs  in  OUTPUT_BITS  from node outputs_t.
REQ-021 out_vec  out  N_NEURONS*OUTPUT_BITS  layer result; neuron k occupies slice [k*OUTPUT_BITS +: OUTPUT_BITS].

Function
REQ-022 The FSM SHALL have states IDLE, FETCH, WAIT, EVAL, STORE, DONE.
- IDLE with start=1 -> FETCH; latch in_vec into node_inputs; set index=0.
- FETCH: w_rd=1 and w_addr=index for exactly 1 cycle -> WAIT.
- WAIT: register w_data into node_weights/node_bias; clear the latency counter -> EVAL.
- EVAL: hold for NODE_LATENCY cycles -> STORE.
- STORE: write node_outputs to slice index of out_vec; if index=N_NEURONS-1 -> DONE, else index+1 -> FETCH.
- DONE: done=1 for 1 cycle -> IDLE.
REQ-023 The block SHALL take 3+NODE_LATENCY cycles per neuron; for start accepted in cycle 0, done SHALL be high in cycle N_NEURONS*(3+NODE_LATENCY)+1.
REQ-024 busy SHALL be 1 in FETCH, WAIT, EVAL and STORE, and 0 in IDLE and DONE.
REQ-025 The block SHALL ignore start unless it is in IDLE, including start asserted in DONE.
REQ-026 When abort=1 in any busy state, the block SHALL enter IDLE on the next cycle, with no done pulse, written out_vec slices retained and unwritten slices unchanged.
REQ-027 When abort and start are both 1 in IDLE, abort SHALL have priority and start SHALL not be accepted.
REQ-028 node_inputs, node_weights and node_bias SHALL remain stable from WAIT through STORE.
REQ-029 out_vec SHALL change only in STORE and SHALL hold its value in IDLE.
REQ-030 w_rd SHALL be 0 in every state except FETCH.

Reset
REQ-031 While reset=0, the block SHALL force state=IDLE, index=0, busy=0, done=0, w_rd=0, w_addr=0, node_inputs=0, node_weights=0, node_bias=0, out_vec=0, independent of clk.
REQ-032 Reset asserted mid-evaluation SHALL discard all progress, and the first start after reset release SHALL begin at neuron 0.

Configuration
REQ-033 The macro NODE_SCHED_PERF_EN SHALL control a performance counter as follows.
- Defined: output cycle_count [15:0] counts the busy=1 cycles of the current run, saturates at 16'hFFFF, clears on start acceptance, is held after DONE or abort, and resets to 0.
- Undefined: the port and counter are absent and all other behaviour is identical.

Verification
REQ-034 The bench SHALL cover these directed scenarios.
- Defaults, w_data row k with all weights=k and bias=k, node model outputs=low 3 bits of its bias, start at cycle 0 -> w_addr sequence 0..7, done high at cycle 33 only, out_vec slice k=k.
- start held high continuously -> exactly one evaluation per IDLE visit, no start accepted while busy=1 or in DONE.
- abort during EVAL of neuron 3 -> IDLE next cycle, no done pulse, slices 0-2 updated, slices 3-7 keep their prior values.
- reset=0 pulsed during WAIT of neuron 5 -> all outputs 0 immediately, next start gives a full correct run.
- NODE_LATENCY=4 -> 7 cycles per neuron, done at cycle 57.
- NODE_SCHED_PERF_EN defined, defaults -> cycle_count=32 after done; undefined -> the build has no cycle_count port.
